// File: rtl/fp_normalizer.sv
// Two-stage normalization pipeline: S1 captures operand + leading-zero count,
// S2 captures the left-shifted mantissa and adjusted exponent.
module fp_normalizer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exponent,
    input  logic [31:0] in_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [9:0]  out_exponent,
    output logic [31:0] out_mantissa,
    output logic [4:0]  out_shift,
    output logic        out_zero,
    output logic        out_subnormal
);

    logic        s1_valid;
    logic        s1_sign;
    logic [9:0]  s1_exp;
    logic [31:0] s1_mant;
    logic [4:0]  s1_lz;
    logic        s1_all_zeros;

    logic [4:0]  lz;
    logic        all_zeros;

    logic        s2_adv;
    logic        s1_adv;

    logic signed [9:0] e_s;
    logic signed [9:0] lz_s;
    logic [9:0]  e_minus_one;
    logic [4:0]  nxt_shift;
    logic [9:0]  nxt_exp;
    logic [31:0] nxt_mant;
    logic        nxt_zero;
    logic        nxt_sub;

    // Leading-zeros detector: the highest set bit wins, so scan upward.
    always_comb begin
        lz        = '0;
        all_zeros = (in_mantissa == '0);
        for (int unsigned i = 0; i < 32; i++) begin
            if (in_mantissa[i[4:0]]) begin
                lz = 5'd31 - i[4:0];
            end
        end
    end

    assign s2_adv   = out_ready || !out_valid;
    assign s1_adv   = s2_adv || !s1_valid;
    assign in_ready = s1_adv;

    assign e_s         = $signed(s1_exp);
    assign lz_s        = $signed({5'b0, s1_lz});
    assign e_minus_one = s1_exp - 10'd1;

    // e > lz is the normal case; 1 <= e <= lz clamps so the exponent lands on 0.
    always_comb begin
        nxt_shift = '0;
        nxt_exp   = s1_exp;
        nxt_zero  = 1'b0;
        nxt_sub   = 1'b0;
        if (s1_all_zeros) begin
            nxt_exp  = '0;
            nxt_zero = 1'b1;
        end else if (e_s <= 10'sd0) begin
            nxt_sub = 1'b1;
        end else if (e_s > lz_s) begin
            nxt_shift = s1_lz;
            nxt_exp   = e_s - lz_s;
        end else begin
            nxt_shift = e_minus_one[4:0];
            nxt_exp   = '0;
            nxt_sub   = 1'b1;
        end
        nxt_mant = s1_all_zeros ? '0 : (s1_mant << nxt_shift);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_exp       <= '0;
            s1_mant      <= '0;
            s1_lz        <= '0;
            s1_all_zeros <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign      <= in_sign;
                s1_exp       <= in_exponent;
                s1_mant      <= in_mantissa;
                s1_lz        <= lz;
                s1_all_zeros <= all_zeros;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_sign      <= 1'b0;
            out_exponent  <= '0;
            out_mantissa  <= '0;
            out_shift     <= '0;
            out_zero      <= 1'b0;
            out_subnormal <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign      <= s1_sign;
                out_exponent  <= nxt_exp;
                out_mantissa  <= nxt_mant;
                out_shift     <= nxt_shift;
                out_zero      <= nxt_zero;
                out_subnormal <= nxt_sub;
            end
        end
    end

endmodule
